instr_feeder: RTL and testbench

- Program sequencer at the producer end of the processor's `din` instruction interface.
- Holds a small loadable program memory of 9-bit instruction words. Drives `din` in lock-step with the processor's one-hot `tick_FSM` (tick 1 = 0001 through tick 4 = 1000, repeating).
- Presents each opcode word during tick 1 and, for two-word instructions (ADDI, MOVI), the immediate word during tick 2.
- Replaces manual switch entry in the top-level wrapper.

---
 rtl/instr_feeder.sv | 145 ++++++++++++++
 tb/tb_instr_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Program sequencer that feeds the processor's din port in lock-step with its one-hot tick_FSM.
// Optional build macro INSTR_FEEDER_LOOP_EN: the program restarts at word 0 instead of stopping in DONE.
module instr_feeder #(
  parameter int unsigned          DEPTH     = 16,
  parameter int unsigned          ADDR_W    = 4,
  parameter int unsigned          DIN_WIDTH = 9,
  parameter logic [DIN_WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_W:0]      prog_len,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DIN_WIDTH-1:0] wr_data,
  input  logic [3:0]           tick,
  output logic [DIN_WIDTH-1:0] din,
  output logic [ADDR_W:0]      pc,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err,
  output logic [7:0]           instr_count
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_OPCODE, S_IMM, S_DONE} state_t;

  logic [DIN_WIDTH-1:0] mem_q [DEPTH];
  state_t               state_q, state_d;
  logic [ADDR_W:0]      pc_q, pc_d;
  logic [7:0]           cnt_q, cnt_d, cnt_inc;
  logic                 wr_err_q, wr_err_d, busy_q, busy_d, done_q, done_d;
  logic [DIN_WIDTH-1:0] op_word, imm_word;
  logic [ADDR_W-1:0]    imm_addr;
  logic [ADDR_W+1:0]    len_ext, pc_inc1, pc_inc2;
  logic [2:0]           opcode;
  logic                 wr_ok, two_word, wrap;

  assign wr_ok    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign op_word  = mem_q[pc_q[ADDR_W-1:0]];
  // Immediate of an instruction at the last address wraps to word 0.
  assign imm_addr = pc_q[ADDR_W-1:0] + ADDR_W'(1);
  assign imm_word = mem_q[imm_addr];
  assign opcode   = op_word[DIN_WIDTH-1 -: 3];
  assign two_word = (opcode == 3'd2) || (opcode == 3'd7);
  assign len_ext  = {1'b0, prog_len};
  assign pc_inc1  = {1'b0, pc_q} + (ADDR_W+2)'(1);
  assign pc_inc2  = {1'b0, pc_q} + (ADDR_W+2)'(2);
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    case (state_q)
      S_IDLE: if (run) begin
        state_d = S_ALIGN;
        pc_d    = '0;
        cnt_d   = '0;
      end
      S_ALIGN: begin
        if (!run)                 state_d = S_IDLE;
        else if (tick == 4'b1000) state_d = (prog_len == '0) ? S_DONE : S_OPCODE;
      end
      S_OPCODE: begin
        if (tick == 4'b0001) begin
          cnt_d = cnt_inc;
          if (two_word) begin
            state_d = S_IMM;
          end else if (pc_inc1 >= len_ext) begin
`ifdef INSTR_FEEDER_LOOP_EN
            pc_d = '0;
            wrap = 1'b1;
`else
            pc_d    = pc_inc1[ADDR_W:0];
            state_d = S_DONE;
`endif
          end else begin
            pc_d = pc_inc1[ADDR_W:0];
          end
        end else if (!run) begin
          state_d = S_IDLE;
        end
      end
      // run is only sampled once the immediate has been consumed.
      S_IMM: if (tick == 4'b0010) begin
        if (pc_inc2 >= len_ext) begin
`ifdef INSTR_FEEDER_LOOP_EN
          pc_d    = '0;
          wrap    = 1'b1;
          state_d = run ? S_OPCODE : S_IDLE;
`else
          pc_d    = pc_inc2[ADDR_W:0];
          state_d = run ? S_DONE : S_IDLE;
`endif
        end else begin
          pc_d    = pc_inc2[ADDR_W:0];
          state_d = run ? S_OPCODE : S_IDLE;
        end
      end
      S_DONE:  if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    wr_err_d = wr_en && !wr_ok;
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d   = (state_d == S_DONE) || wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OPCODE: din = op_word;
      S_IMM:    din = imm_word;
      default:  din = IDLE_WORD;
    endcase
  end

  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_err      = wr_err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a consumer model captures din at tick1/tick2 and checks it against a queue of expected words.
module tb_instr_feeder;
  logic       clk = 1'b0, rst = 1'b1, run = 1'b0, wr_en = 1'b0;
  logic [4:0] prog_len = '0;
  logic [3:0] wr_addr = '0, tick = '0;
  logic [8:0] wr_data = '0, din;
  logic [4:0] pc;
  logic       busy, done, wr_err;
  logic [7:0] instr_count;

  instr_feeder dut (
    .clk(clk), .rst(rst), .run(run), .prog_len(prog_len), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .tick(tick), .din(din), .pc(pc),
    .busy(busy), .done(done), .wr_err(wr_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  logic [8:0] sb_q [$];
  logic       tick_en = 1'b1;
  logic [7:0] regs [8];
  logic [7:0] disp = '0;
  logic       imm_pend = 1'b0;
  logic [2:0] imm_op = '0, imm_rx = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm, input logic [8:0] w);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected word %0h, expected none", nm, w);
    end else begin
      chk(nm, 32'(w), 32'(sb_q.pop_front()));
    end
  endtask

  // Processor tick_FSM: rotates 0001..1000, holds 0000 while frozen.
  initial forever begin
    @(posedge clk); #1;
    if (!tick_en)            tick = 4'b0000;
    else if (tick == 4'b0000) tick = 4'b0001;
    else                      tick = {tick[2:0], tick[3]};
  end

  // Consumer model: opcode captured at tick1, immediate at the following tick2.
  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        imm_pend = 1'b0;
      end else if (imm_pend && tick == 4'b0010) begin
        sb_pop("imm_word", din);
        if (imm_op == 3'd7) regs[imm_rx] = din[7:0];
        else                regs[imm_rx] = regs[imm_rx] + din[7:0];
        imm_pend = 1'b0;
      end else if (tick == 4'b0001 && din != 9'h000) begin
        sb_pop("op_word", din);
        if (din[8:6] == 3'd2 || din[8:6] == 3'd7) begin
          imm_pend = 1'b1;
          imm_op   = din[8:6];
          imm_rx   = din[5:3];
        end else if (din[8:6] == 3'd1) begin
          regs[din[5:3]] = regs[din[5:3]] + regs[din[2:0]];
        end else if (din[8:6] == 3'd0) begin
          disp = regs[din[5:3]];
        end
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] len);
    run = 1'b0;
    @(posedge clk); #1;
    prog_len = len;
    run      = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin @(posedge clk); #1; end
    chk(nm, 32'(done), 1);
  endtask

  task automatic push_prog();
    sb_q.push_back(9'h1C8); sb_q.push_back(9'h005);
    sb_q.push_back(9'h049); sb_q.push_back(9'h008);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_din", 32'(din), 0);
    @(posedge clk); #1 rst = 1'b1;
    wr(4'd0, 9'h1C8); wr(4'd1, 9'h005); wr(4'd2, 9'h049); wr(4'd3, 9'h008);

`ifdef INSTR_FEEDER_LOOP_EN
    push_prog();
    sb_q.push_back(9'h1C8); sb_q.push_back(9'h005);
    go(5'd4);
    wait_done("loop_done_pulse");
    chk("loop_pc_wrap", 32'(pc), 0);
    chk("loop_busy", 32'(busy), 1);
    chk("loop_count3", 32'(instr_count), 3);
    @(posedge clk); #1;
    chk("loop_done_low", 32'(done), 0);
    for (int i = 0; i < 10 && instr_count != 8'd4; i++) begin @(posedge clk); #1; end
    chk("loop_count4", 32'(instr_count), 4);
    run = 1'b0;
    @(posedge clk); #1;
    chk("loop_idle", 32'(busy), 0);
    chk("loop_drained", 32'(sb_q.size()), 0);
`else
    // Main program: MOVI R1,5; ADD R1,R1; DISP R1.
    push_prog();
    go(5'd4);
    wait_done("t1_done");
    chk("t1_pc", 32'(pc), 4);
    chk("t1_count", 32'(instr_count), 3);
    chk("t1_display", 32'(disp), 10);
    chk("t1_drained", 32'(sb_q.size()), 0);

    // Empty program, with tick frozen at 0000 first: ALIGN must hold.
    run = 1'b0; tick_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    prog_len = 5'd0; run = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("t2_hold_busy", 32'(busy), 1);
    chk("t2_hold_done", 32'(done), 0);
    tick_en = 1'b1;
    wait_done("t2_done");
    chk("t2_din", 32'(din), 0);
    chk("t2_count", 32'(instr_count), 0);

    // Write while busy is rejected and the program still sees 049.
    push_prog();
    go(5'd4);
    @(posedge clk); #1;
    chk("t3_busy", 32'(busy), 1);
    wr(4'd2, 9'h1FF);
    chk("t3_wr_err", 32'(wr_err), 1);
    @(posedge clk); #1;
    chk("t3_wr_err_pulse", 32'(wr_err), 0);
    wait_done("t3_done");
    chk("t3_drained", 32'(sb_q.size()), 0);
    chk("t3_display", 32'(disp), 10);

    // Drop run while the MOVI immediate is pending.
    sb_q.push_back(9'h1C8); sb_q.push_back(9'h005);
    go(5'd4);
    for (int i = 0; i < 30 && !(tick == 4'b0001 && din == 9'h1C8); i++) @(negedge clk);
    chk("t4_movi_seen", 32'(din), 32'h1C8);
    @(posedge clk); #1 run = 1'b0;
    @(posedge clk); #1;
    chk("t4_pc", 32'(pc), 2);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_din", 32'(din), 0);
    chk("t4_drained", 32'(sb_q.size()), 0);

    // Async reset mid-OPCODE at pc=2, then a clean re-run.
    sb_q.push_back(9'h1C8); sb_q.push_back(9'h005);
    go(5'd4);
    for (int i = 0; i < 30 && !(pc == 5'd2 && tick == 4'b0100); i++) @(negedge clk);
    chk("t5_pc_pre", 32'(pc), 2);
    rst = 1'b0;
    #1;
    chk("t5_pc", 32'(pc), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_din", 32'(din), 0);
    chk("t5_drained", 32'(sb_q.size()), 0);
    push_prog();
    @(posedge clk); #1 rst = 1'b1;
    wait_done("t5_rerun_done");
    chk("t5_rerun_display", 32'(disp), 10);
    chk("t5_rerun_drained", 32'(sb_q.size()), 0);

    // Two-word instruction at the last valid word: pc ends at prog_len+1.
    sb_q.push_back(9'h1C8); sb_q.push_back(9'h005);
    go(5'd1);
    wait_done("t6_done");
    chk("t6_pc", 32'(pc), 2);
    chk("t6_count", 32'(instr_count), 1);
    chk("t6_drained", 32'(sb_q.size()), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
